// File: rtl/io_bridge_if.sv
// io_bridge_if: bus bundle between the vixen CPU port, the io_bridge and its
// peripheral register blocks.
//   cpu_*      CPU request / response (en, wr, wide, addr, wdata, rdata, busy, ready)
//   mem_sel    memory select for accesses outside the I/O window
//   per_*      registered peripheral strobes plus packed read data and acks
//   err_*      sticky bus-error flag, failing address, and clear strobe
// Modport slave is the bridge's view; master is the CPU/peripheral side.
interface io_bridge_if #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_SHIFT = 6
);
  logic                     cpu_en;
  logic                     cpu_wr;
  logic                     cpu_wide;
  logic [15:0]              cpu_addr;
  logic [15:0]              cpu_wdata;
  logic [15:0]              cpu_rdata;
  logic                     cpu_busy;
  logic                     cpu_ready;
  logic                     mem_sel;
  logic [NUM_CH-1:0]        per_sel;
  logic                     per_wr;
  logic                     per_wide;
  logic [CH_SHIFT-1:0]      per_addr;
  logic [15:0]              per_wdata;
  logic [16*NUM_CH-1:0]     per_rdata;
  logic [NUM_CH-1:0]        per_ack;
  logic                     err_clr;
  logic                     err_flag;
  logic [15:0]              err_addr;

  modport slave (
    input  cpu_en, cpu_wr, cpu_wide, cpu_addr, cpu_wdata, per_rdata, per_ack, err_clr,
    output cpu_rdata, cpu_busy, cpu_ready, mem_sel, per_sel, per_wr, per_wide, per_addr,
           per_wdata, err_flag, err_addr
  );

  modport master (
    output cpu_en, cpu_wr, cpu_wide, cpu_addr, cpu_wdata, per_rdata, per_ack, err_clr,
    input  cpu_rdata, cpu_busy, cpu_ready, mem_sel, per_sel, per_wr, per_wide, per_addr,
           per_wdata, err_flag, err_addr
  );
endinterface

// File: rtl/io_bridge.sv
// io_bridge: memory-mapped I/O bridge from the vixen CPU port to NUM_CH
// peripheral register blocks.
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset
//   bus_io  io_bridge_if slave: CPU request/stall/ready, memory select,
//           registered peripheral strobes, per-channel ack/read data,
//           sticky bus-error status
// Accesses inside the I/O window are decoded to a channel; mapped channels are
// held in ACCESS until ack or watchdog timeout, unmapped ones error at once.
// Every I/O access ends with a one-cycle DONE carrying cpu_ready.
module io_bridge #(
  parameter int unsigned NUM_CH   = 4,
  parameter logic [5:0]  IO_BASE  = 6'h3f,
  parameter int unsigned CH_SHIFT = 6,
  parameter int unsigned TIMEOUT  = 15
) (
  input logic        clk,
  input logic        reset,
  io_bridge_if.slave bus_io
);

  localparam int unsigned ChW = 10 - CH_SHIFT;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [15:0]         addr_q, addr_d;
  logic                wr_q, wr_d;
  logic                wide_q, wide_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [NUM_CH-1:0]   sel_q, sel_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                err_flag_q, err_flag_d;
  logic [15:0]         err_addr_q, err_addr_d;

  logic                io_hit;
  logic [ChW-1:0]      ch_idx;
  logic                ch_mapped;
  logic [NUM_CH-1:0]   ch_onehot;
  logic                ack_hit;
  logic [15:0]         rdata_mux;
  logic                set_err;

  assign io_hit    = (bus_io.cpu_addr[15:10] == IO_BASE);
  assign ch_idx    = bus_io.cpu_addr[9:CH_SHIFT];
  assign ch_mapped = (32'(ch_idx) < NUM_CH);

  always_comb begin
    ch_onehot = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      ch_onehot[k] = (32'(ch_idx) == k);
    end
  end

  // Only the selected channel's ack and read data are observed.
  assign ack_hit = |(bus_io.per_ack & sel_q);

  always_comb begin
    rdata_mux = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (sel_q[k]) begin
        rdata_mux = bus_io.per_rdata[16*k +: 16];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wide_d  = wide_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    set_err = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus_io.cpu_en && io_hit) begin
          addr_d  = bus_io.cpu_addr;
          wr_d    = bus_io.cpu_wr;
          wide_d  = bus_io.cpu_wide;
          wdata_d = bus_io.cpu_wdata;
          cnt_d   = 8'd0;
          if (ch_mapped) begin
            sel_d   = ch_onehot;
            state_d = StAccess;
          end else begin
            rdata_d = 16'hffff;
            set_err = 1'b1;
            state_d = StDone;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 8'd1;
        // Ack is tested first so it wins over a coincident timeout.
        if (ack_hit) begin
          rdata_d = wide_q ? rdata_mux : {8'h00, rdata_mux[7:0]};
          sel_d   = '0;
          state_d = StDone;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          rdata_d = 16'hffff;
          set_err = 1'b1;
          sel_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // addr_d holds the failing address in both error paths (fresh or latched).
  assign err_addr_d = set_err ? addr_d : err_addr_q;
  assign err_flag_d = set_err | (err_flag_q & ~bus_io.err_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      addr_q     <= 16'h0000;
      wr_q       <= 1'b0;
      wide_q     <= 1'b0;
      wdata_q    <= 16'h0000;
      sel_q      <= '0;
      rdata_q    <= 16'h0000;
      err_flag_q <= 1'b0;
      err_addr_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wide_q     <= wide_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      rdata_q    <= rdata_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus_io.cpu_rdata = rdata_q;
  assign bus_io.cpu_ready = (state_q == StDone);
  assign bus_io.cpu_busy  = (state_q == StAccess) ||
                            ((state_q == StIdle) && bus_io.cpu_en && io_hit);
  assign bus_io.mem_sel   = bus_io.cpu_en & ~io_hit;
  assign bus_io.per_sel   = sel_q;
  assign bus_io.per_wr    = wr_q;
  assign bus_io.per_wide  = wide_q;
  assign bus_io.per_addr  = addr_q[CH_SHIFT-1:0];
  assign bus_io.per_wdata = wdata_q;
  assign bus_io.err_flag  = err_flag_q;
  assign bus_io.err_addr  = err_addr_q;

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: self-checking bench for io_bridge (NUM_CH=4, TIMEOUT=15).
// Table-driven directed vectors, randomized transactions checked against a
// transaction-level latency/data/error model, and hand sequences for the
// memory pass-through, err_clr and reset-during-access cases.
module tb_io_bridge;

  localparam int unsigned NCh = 4;
  localparam int unsigned Tmo = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  io_bridge_if #(.NUM_CH(NCh), .CH_SHIFT(6)) bus ();

  io_bridge #(
    .NUM_CH  (NCh),
    .IO_BASE (6'h3f),
    .CH_SHIFT(6),
    .TIMEOUT (Tmo)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0]    addr;
    logic           wr;
    logic           wide;
    logic [15:0]    wdata;
    int             dly;
    logic [15:0]    pdata;
    logic           clr;
    int             lat;
    logic [15:0]    rd;
    logic           err;
    logic           flag;
    logic [NCh-1:0] sel;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One I/O transaction: request in cycle 0, ack pulsed dly cycles after
  // per_sel rises (never if dly is out of range), held until cpu_ready.
  task automatic run_txn(input logic [15:0] addr, input logic wr, input logic wide,
                         input logic [15:0] wdata, input int dly, input logic [15:0] pdata,
                         input logic clr, input int e_lat, input logic [15:0] e_rd,
                         input logic e_err, input logic e_flag, input logic [NCh-1:0] e_sel);
    int chi;
    int lat;
    bit seen;
    chi = int'(addr[9:6]);
    @(posedge clk); #1;
    bus.cpu_en    = 1'b1;
    bus.cpu_wr    = wr;
    bus.cpu_wide  = wide;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.err_clr   = clr;
    bus.per_ack   = '0;
    for (int k = 0; k < NCh; k++) bus.per_rdata[16*k +: 16] = 16'($urandom);
    if (chi < NCh) bus.per_rdata[16*chi +: 16] = pdata;
    @(negedge clk);
    check("req_busy", 32'(bus.cpu_busy), 32'(1));
    check("req_mem_sel", 32'(bus.mem_sel), 32'(0));
    seen = 1'b0;
    lat  = 0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(posedge clk); #1;
      bus.err_clr = 1'b0;
      bus.per_ack = NCh'($urandom) & ~e_sel;
      if (cyc - 1 == dly) bus.per_ack = bus.per_ack | e_sel;
      @(negedge clk);
      if (cyc == 1 && e_lat > 1) begin
        check("per_sel", 32'(bus.per_sel), 32'(e_sel));
        check("per_addr", 32'(bus.per_addr), 32'(addr[5:0]));
        check("per_wr", 32'(bus.per_wr), 32'(wr));
        check("per_wide", 32'(bus.per_wide), 32'(wide));
        check("per_wdata", 32'(bus.per_wdata), 32'(wdata));
        check("access_busy", 32'(bus.cpu_busy), 32'(1));
      end
      if (bus.cpu_ready) begin
        seen = 1'b1;
        lat  = cyc;
      end
    end
    check("ready_seen", 32'(seen), 32'(1));
    check("latency", lat, e_lat);
    if (seen) begin
      if (!wr) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_rd));
      check("done_busy", 32'(bus.cpu_busy), 32'(0));
      check("done_per_sel", 32'(bus.per_sel), 32'(0));
      check("err_flag", 32'(bus.err_flag), 32'(e_flag));
      if (e_err) check("err_addr", 32'(bus.err_addr), 32'(addr));
    end
    bus.per_ack = '0;
  endtask

  task automatic mem_access(input logic [15:0] addr);
    @(posedge clk); #1;
    bus.cpu_en   = 1'b1;
    bus.cpu_wr   = 1'($urandom);
    bus.cpu_addr = addr;
    @(negedge clk);
    check("mem_sel", 32'(bus.mem_sel), 32'(1));
    check("mem_busy", 32'(bus.cpu_busy), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("mem_no_ready", 32'(bus.cpu_ready), 32'(0));
    check("mem_no_sel", 32'(bus.per_sel), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        m_flag;
    logic [15:0] addr;
    logic [9:0]  off;
    logic        wr, wide, clr, mapped, e_err, e_flag;
    logic [15:0] wdata, pdata, e_rd;
    logic [NCh-1:0] e_sel;
    int          dly, e_lat, chi;

    //          addr      wr    wide  wdata     dly  pdata     clr   lat rd        err   flag  sel
    tbl[0] = '{16'hfc40, 1'b0, 1'b1, 16'h0000, 2,   16'hbeef, 1'b0, 4,  16'hbeef, 1'b0, 1'b0, 4'b0010};
    tbl[1] = '{16'hfc05, 1'b1, 1'b0, 16'h005a, 0,   16'h0000, 1'b0, 2,  16'h0000, 1'b0, 1'b0, 4'b0001};
    tbl[2] = '{16'hfc80, 1'b0, 1'b1, 16'h0000, 255, 16'h1111, 1'b0, 17, 16'hffff, 1'b1, 1'b1, 4'b0100};
    tbl[3] = '{16'hff00, 1'b0, 1'b1, 16'h0000, 0,   16'h0000, 1'b0, 1,  16'hffff, 1'b1, 1'b1, 4'b0000};
    tbl[4] = '{16'hfcc3, 1'b0, 1'b0, 16'h0000, 15,  16'h1234, 1'b1, 17, 16'h0034, 1'b0, 1'b0, 4'b1000};
    tbl[5] = '{16'hfc7f, 1'b0, 1'b1, 16'h0000, 1,   16'ha55a, 1'b0, 3,  16'ha55a, 1'b0, 1'b0, 4'b0010};
    tbl[6] = '{16'hfd00, 1'b0, 1'b0, 16'h0000, 0,   16'h0000, 1'b1, 1,  16'hffff, 1'b1, 1'b1, 4'b0000};
    tbl[7] = '{16'hfc00, 1'b0, 1'b1, 16'h0000, 16,  16'h7777, 1'b1, 17, 16'hffff, 1'b1, 1'b1, 4'b0001};
    tbl[8] = '{16'hfcfe, 1'b1, 1'b1, 16'hc0de, 3,   16'h0000, 1'b1, 5,  16'h0000, 1'b0, 1'b0, 4'b1000};

    reset         = 1'b1;
    bus.cpu_en    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_wide  = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 16'h0000;
    bus.per_rdata = '0;
    bus.per_ack   = '0;
    bus.err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_per_sel", 32'(bus.per_sel), 32'(0));
    check("rst_per_wr", 32'(bus.per_wr), 32'(0));
    check("rst_per_wide", 32'(bus.per_wide), 32'(0));
    check("rst_per_addr", 32'(bus.per_addr), 32'(0));
    check("rst_per_wdata", 32'(bus.per_wdata), 32'(0));
    check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'(0));
    check("rst_cpu_ready", 32'(bus.cpu_ready), 32'(0));
    check("rst_cpu_busy", 32'(bus.cpu_busy), 32'(0));
    check("rst_err_flag", 32'(bus.err_flag), 32'(0));
    check("rst_err_addr", 32'(bus.err_addr), 32'(0));

    // Directed table; transactions chain back-to-back into cycle M+2.
    m_flag = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].addr, tbl[i].wr, tbl[i].wide, tbl[i].wdata, tbl[i].dly, tbl[i].pdata,
              tbl[i].clr, tbl[i].lat, tbl[i].rd, tbl[i].err, tbl[i].flag, tbl[i].sel);
      m_flag = tbl[i].flag;
    end

    // Memory pass-through never stalls nor touches the peripheral side.
    mem_access(16'h1234);

    // Standalone err_clr after an unmapped access; I/O address without cpu_en.
    run_txn(16'hfd40, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, 1'b0, 1, 16'hffff, 1'b1, 1'b1, '0);
    @(posedge clk); #1;
    bus.cpu_en   = 1'b0;
    bus.cpu_addr = 16'hfc40;
    bus.err_clr  = 1'b1;
    @(negedge clk);
    check("idle_io_no_en_busy", 32'(bus.cpu_busy), 32'(0));
    check("idle_io_no_en_mem_sel", 32'(bus.mem_sel), 32'(0));
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    @(negedge clk);
    check("err_clr_flag", 32'(bus.err_flag), 32'(0));
    check("err_clr_addr_kept", 32'(bus.err_addr), 32'(16'hfd40));
    m_flag = 1'b0;

    // Randomized transactions against the transaction-level model.
    for (int n = 0; n < 60; n++) begin
      off      = 10'($urandom);
      off[9:6] = 4'($urandom_range(0, 5));
      addr     = {6'h3f, off};
      wr       = 1'($urandom);
      wide     = 1'($urandom);
      wdata    = 16'($urandom);
      pdata    = 16'($urandom);
      dly      = int'($urandom_range(0, 18));
      if ($urandom_range(0, 5) == 0) dly = 255;
      clr      = ($urandom_range(0, 3) == 0);
      chi      = int'(off[9:6]);
      mapped   = (chi < NCh);
      e_err    = !mapped || (dly > Tmo);
      e_lat    = !mapped ? 1 : ((dly <= Tmo) ? dly + 2 : Tmo + 2);
      e_rd     = e_err ? 16'hffff : (wide ? pdata : {8'h00, pdata[7:0]});
      e_flag   = e_err | (m_flag & ~clr);
      e_sel    = mapped ? NCh'(1 << chi) : '0;
      run_txn(addr, wr, wide, wdata, dly, pdata, clr, e_lat, e_rd, e_err, e_flag, e_sel);
      m_flag = e_flag;
      if ($urandom_range(0, 4) == 0) begin
        mem_access({6'($urandom_range(0, 62)), 10'($urandom)});
      end
    end

    // Reset in the middle of an access aborts it without ready or error.
    run_txn(16'hff40, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, 1'b0, 1, 16'hffff, 1'b1, 1'b1, '0);
    @(posedge clk); #1;
    bus.cpu_addr = 16'hfc00;
    bus.cpu_wr   = 1'b0;
    bus.cpu_wide = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_per_sel", 32'(bus.per_sel), 32'(4'b0001));
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_per_sel", 32'(bus.per_sel), 32'(0));
    check("reset_no_ready", 32'(bus.cpu_ready), 32'(0));
    check("reset_err_flag", 32'(bus.err_flag), 32'(0));
    bus.cpu_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_hold_ready", 32'(bus.cpu_ready), 32'(0));
    reset = 1'b0;
    run_txn(16'hfc02, 1'b0, 1'b1, 16'h0000, 0, 16'h0bad, 1'b0, 2, 16'h0bad, 1'b0, 1'b0,
            4'b0001);
    @(posedge clk); #1;
    bus.cpu_en = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_bridge.md
# io_bridge

Parametrised memory-mapped I/O bridge between the `vixen` CPU port and up to `NUM_CH` peripheral register blocks. It replaces the single hard-wired video-register decode with:
- an address-window decoder;
- a per-channel request/acknowledge handshake;
- a registered read-data return with CPU stall;
- a bus-timeout watchdog with latched error status.

Addresses outside the I/O window pass straight through to `memory` via `mem_sel`.

## Interface
Parameters:
- `NUM_CH`, 4: number of peripheral channels, 1..16.
- `IO_BASE`, 6'h3f: value of `cpu_addr[15:10]` selecting the 1 KiB I/O window (fc00-ffff).
- `CH_SHIFT`, 6: log2 bytes per channel window. Channel index = `cpu_addr[9:CH_SHIFT]`.
- `TIMEOUT`, 15: ACCESS cycles without ack before a bus error, 1..255.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_en`  in  1  CPU access strobe.
- `cpu_wr`  in  1  1 = write.
- `cpu_wide`  in  1  1 = 16-bit, 0 = 8-bit.
- `cpu_addr`  in  16  byte address.
- `cpu_wdata`  in  16  write data.
- `cpu_rdata`  out  16  read data, valid while `cpu_ready`.
- `cpu_busy`  out  1  CPU must hold its request and stall.
- `cpu_ready`  out  1  one-cycle I/O completion pulse.
- `mem_sel`  out  1  combinational: `cpu_en` and address outside the I/O window.
- `per_sel`  out  NUM_CH  one-hot channel select.
- `per_wr`, `per_wide`  out  1 each  latched access type.
- `per_addr`  out  CH_SHIFT  offset within the channel window.
- `per_wdata`  out  16  latched write data.
- `per_rdata`  in  16*NUM_CH  packed read data; channel k at [16k+15:16k].
- `per_ack`  in  NUM_CH  channel completion, sampled only for the selected channel.
- `err_clr`  in  1  clears `err_flag`.
- `err_flag`  out  1  sticky bus-error flag.
- `err_addr`  out  16  address of the most recent failed access.

## Operation
- `io_hit` = `cpu_addr[15:10] == IO_BASE`.
- A channel is mapped when its index is < `NUM_CH`. Indices ≥ `NUM_CH` are unmapped.
- FSM states are IDLE, ACCESS and DONE.
- IDLE, when `cpu_en & io_hit`:
  - latch addr, wr, wide and wdata;
  - if the channel is mapped, go to ACCESS and load the timeout counter with 0;
  - if the channel is unmapped, go to DONE with error.
- ACCESS:
  - `per_sel[ch]` = 1 and the counter increments every cycle.
  - When `per_ack[ch]` = 1, capture `per_rdata[ch]` and go to DONE (ok).
  - Else, when the counter reaches `TIMEOUT`, go to DONE with error.
  - If ack and timeout fall in the same cycle, ack wins.
- DONE lasts one cycle, then returns to IDLE:
  - `cpu_ready` = 1 and `per_sel` = 0.
  - `cpu_rdata` = captured data. For byte reads (`wide`=0) it is `{8'h00, data[7:0]}`. On error it is 16'hffff.
  - Writes complete the same way; `cpu_rdata` is don't-care.
- Error: `err_flag` is set and `err_addr` loaded with the latched address.
  - `err_clr` clears the flag.
  - If a new error and `err_clr` occur in the same cycle, the error wins.
- `cpu_busy` = (state != IDLE && state != DONE) || (state == IDLE && `cpu_en` && `io_hit`).
- `cpu_en` in ACCESS or DONE is ignored; the CPU holds its request until `cpu_ready`.
- Non-I/O accesses never change state and never stall.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `per_sel` 0, `per_wr` 0, `per_wide` 0, `per_addr` 0, `per_wdata` 0;
  - `cpu_rdata` 0, `cpu_ready` 0;
  - `err_flag` 0, `err_addr` 0.
- Request accepted at edge N. `per_sel` is high from N+1. An ack seen at edge M gives `cpu_ready` in cycle M+1, and IDLE is reached at M+2.
- Minimum I/O latency (ack in the first ACCESS cycle) is 2 cycles from request to `cpu_ready`. The next request can be accepted in cycle M+2.
- Timeout: with no ack, `cpu_ready` asserts `TIMEOUT`+2 cycles after the request.
- Unmapped channel: `cpu_ready` and the error occur in cycle N+1.
- `per_*` outputs are registered and stable for the whole of ACCESS.
- Peripherals must drop `per_ack` when `per_sel` falls.
- `mem_sel` is purely combinational, with zero latency.
- Reset asserted mid-access aborts it immediately. No `cpu_ready` is produced, no error is flagged, and `per_sel` drops asynchronously.

## Test plan
- Read of fc40 (ch1) with `per_rdata[ch1]`=16'hbeef and ack 2 cycles after `per_sel` → `per_sel`=4'b0010, `per_addr`=0, and `cpu_ready` with `cpu_rdata`=16'hbeef, 4 cycles after the request. No error.
- Byte write 8'h5a to fc05 with same-cycle ack → `per_sel`=4'b0001, `per_addr`=5, `per_wr`=1, `per_wide`=0, `per_wdata`=16'h005a. `cpu_ready` 2 cycles after the request.
- Read of fc80 (ch2) with ack never given, `TIMEOUT`=15 → `cpu_ready` 17 cycles after the request, `cpu_rdata`=16'hffff, `err_flag`=1, `err_addr`=16'hfc80. Then pulse `err_clr` → `err_flag`=0.
- Access to ff00 (channel 12 ≥ `NUM_CH`) → no `per_sel`, `cpu_ready` next cycle, `err_flag`=1, `err_addr`=16'hff00.
- Access to 1234 → `mem_sel`=1 and `cpu_busy`=0 in the same cycle; state stays IDLE and `per_sel` stays 0.
- Assert `reset` during ACCESS → `per_sel`=0 at once, no `cpu_ready`, `err_flag`=0. A later ch0 read completes normally.
